// File: rtl/lcd_frame_buffer_if.sv
// ---------------------------------------------------------------------------
// lcd_frame_buffer_if
// Bus bundle between game logic / LCD driver and lcd_frame_buffer.
//   pix_valid  : pixel request valid                (master -> slave)
//   pix_ready  : request accepted when valid&ready  (slave  -> master)
//   pix_x      : pixel column 0..127                (master -> slave)
//   pix_y      : pixel row 0..63                    (master -> slave)
//   pix_op     : 00 clear, 01 set, 10 toggle, 11 clear screen
//   rd_addr    : driver byte address {chip, page, column}
//   rd_data    : byte at rd_addr, one cycle later   (slave  -> master)
// ---------------------------------------------------------------------------
interface lcd_frame_buffer_if;
  logic       pix_valid;
  logic       pix_ready;
  logic [6:0] pix_x;
  logic [5:0] pix_y;
  logic [1:0] pix_op;
  logic [9:0] rd_addr;
  logic [7:0] rd_data;

  modport master (
    output pix_valid, pix_x, pix_y, pix_op, rd_addr,
    input  pix_ready, rd_data
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, pix_op, rd_addr,
    output pix_ready, rd_data
  );
endinterface

// File: rtl/lcd_frame_buffer.sv
// ---------------------------------------------------------------------------
// lcd_frame_buffer
// Holds the 128x64 monochrome image as 1024 bytes in the page/column layout
// the LCD driver scans. Pixel requests are applied as read-modify-write on
// port A; the driver reads bytes on port B. A refresh strobe is issued at a
// fixed frame rate, but only when the image changed since the last strobe.
// Ports:
//   clk     : system clock, rising edge
//   rst     : asynchronous reset, active-high
//   bus     : pixel request port + driver read port (slave modport)
//   start_o : refresh strobe to the driver, START_W cycles wide
//   busy_o  : high while the request FSM is not idle
// ---------------------------------------------------------------------------
module lcd_frame_buffer #(
  parameter int unsigned FRAME_DIV = 500000,
  parameter int unsigned START_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  lcd_frame_buffer_if.slave   bus,
  output logic                start_o,
  output logic                busy_o
);

  localparam int unsigned FC_W = $clog2(FRAME_DIV);
  localparam int unsigned SC_W = $clog2(START_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_MODIFY = 3'd2,
    ST_WRITE  = 3'd3,
    ST_CLEAR  = 3'd4
  } state_t;

  // New byte for a single-pixel op; op 11 never reaches this path.
  function automatic logic [7:0] modify_byte(input logic [7:0] old_byte,
                                             input logic [2:0] bit_idx,
                                             input logic [1:0] op);
    logic [7:0] mask;
    mask = 8'h01 << bit_idx;
    case (op)
      2'b00:   return old_byte & ~mask;
      2'b01:   return old_byte | mask;
      2'b10:   return old_byte ^ mask;
      default: return old_byte;
    endcase
  endfunction

  state_t          state_r;
  logic            pix_ready_r;
  logic            busy_r;
  logic [9:0]      addr_r;
  logic [2:0]      bit_r;
  logic [1:0]      op_r;
  logic [9:0]      clr_ptr_r;
  logic [7:0]      wdata_r;

  logic [7:0]      mem_r [0:1023];
  logic [7:0]      a_rdata_r;
  logic [7:0]      rd_data_r;

  logic            a_we_s;
  logic [9:0]      a_addr_s;
  logic [7:0]      a_wdata_s;
  logic            dirty_set_s;

  logic [FC_W-1:0] frame_cnt_r;
  logic [SC_W-1:0] start_cnt_r;
  logic            start_r;
  logic            dirty_r;
  logic            wrap_s;
  logic            fire_s;

  // Port A controls: CLEAR walks the pointer, WRITE stores the modified byte.
  always_comb begin
    a_we_s      = 1'b0;
    a_addr_s    = addr_r;
    a_wdata_s   = wdata_r;
    dirty_set_s = 1'b0;
    case (state_r)
      ST_WRITE: begin
        a_we_s      = 1'b1;
        a_addr_s    = addr_r;
        a_wdata_s   = wdata_r;
        dirty_set_s = 1'b1;
      end
      ST_CLEAR: begin
        a_we_s      = 1'b1;
        a_addr_s    = clr_ptr_r;
        a_wdata_s   = 8'h00;
        dirty_set_s = (clr_ptr_r == 10'd1023);
      end
      default: begin
        a_we_s      = 1'b0;
        a_addr_s    = addr_r;
        a_wdata_s   = wdata_r;
        dirty_set_s = 1'b0;
      end
    endcase
  end

  // Request FSM with registered ready/busy; reset drops any in-flight write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      pix_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      addr_r      <= 10'd0;
      bit_r       <= 3'd0;
      op_r        <= 2'b00;
      clr_ptr_r   <= 10'd0;
      wdata_r     <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.pix_valid) begin
            addr_r      <= {bus.pix_x[6], bus.pix_y[5:3], bus.pix_x[5:0]};
            bit_r       <= bus.pix_y[2:0];
            op_r        <= bus.pix_op;
            clr_ptr_r   <= 10'd0;
            pix_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= (bus.pix_op == 2'b11) ? ST_CLEAR : ST_READ;
          end else begin
            pix_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        // a_rdata_r captures the latched address at the end of this cycle.
        ST_READ:   state_r <= ST_MODIFY;
        ST_MODIFY: begin
          wdata_r <= modify_byte(a_rdata_r, bit_r, op_r);
          state_r <= ST_WRITE;
        end
        ST_WRITE: begin
          state_r     <= ST_IDLE;
          pix_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
        ST_CLEAR: begin
          clr_ptr_r <= clr_ptr_r + 10'd1;
          if (clr_ptr_r == 10'd1023) begin
            state_r     <= ST_IDLE;
            pix_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          pix_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // Port A: write plus registered read of the latched request address.
  always_ff @(posedge clk) begin
    if (a_we_s) begin
      mem_r[a_addr_s] <= a_wdata_s;
    end
    a_rdata_r <= mem_r[addr_r];
  end

  // Port B: registered driver read; a same-cycle port A write returns the old byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r <= 8'h00;
    end else begin
      rd_data_r <= mem_r[bus.rd_addr];
    end
  end

  assign wrap_s = (frame_cnt_r == FC_W'(FRAME_DIV - 1));
  assign fire_s = wrap_s & dirty_r & ~start_r;

  // Frame pacing: free-running frame counter, dirty flag and start strobe.
  // A dirty set coinciding with a fire wins, so that write gets the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_r <= '0;
      start_cnt_r <= '0;
      start_r     <= 1'b0;
      dirty_r     <= 1'b1;
    end else begin
      frame_cnt_r <= wrap_s ? '0 : frame_cnt_r + FC_W'(1);

      if (dirty_set_s) begin
        dirty_r <= 1'b1;
      end else if (fire_s) begin
        dirty_r <= 1'b0;
      end else begin
        dirty_r <= dirty_r;
      end

      if (fire_s) begin
        start_r     <= 1'b1;
        start_cnt_r <= SC_W'(START_W - 1);
      end else if (start_cnt_r != '0) begin
        start_cnt_r <= start_cnt_r - SC_W'(1);
      end else begin
        start_r <= 1'b0;
      end
    end
  end

  assign bus.pix_ready = pix_ready_r;
  assign bus.rd_data   = rd_data_r;
  assign start_o       = start_r;
  assign busy_o        = busy_r;

endmodule

// File: tb/tb_lcd_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_lcd_frame_buffer
// Directed self-checking bench for lcd_frame_buffer with FRAME_DIV=16,
// START_W=4. Each scenario task drives its stimulus and checks inline.
// ---------------------------------------------------------------------------
module tb_lcd_frame_buffer;

  logic clk;
  logic rst;
  logic start_o;
  logic busy_o;
  int   checks;
  int   errors;

  lcd_frame_buffer_if bus ();

  lcd_frame_buffer #(.FRAME_DIV(16), .START_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .start_o (start_o),
    .busy_o  (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset released at a falling edge: the next rising edge is cycle 1.
  task automatic do_reset();
    bus.pix_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic read_byte(input logic [9:0] a, output logic [7:0] d);
    bus.rd_addr = a;
    @(posedge clk);
    #1;
    d = bus.rd_data;
  endtask

  task automatic pixel_op(input logic [6:0] x, input logic [5:0] y, input logic [1:0] op);
    int n;
    bus.pix_x = x;
    bus.pix_y = y;
    bus.pix_op = op;
    bus.pix_valid = 1'b1;
    n = 0;
    while (!bus.pix_ready && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
    n = 0;
    while (!bus.pix_ready && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!bus.pix_ready) begin
      errors++;
      $display("FAIL op_done timeout: ready=%0b want 1", bus.pix_ready);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.pix_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.pix_ready); end
    checks++;
    if (start_o !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", start_o); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    checks++;
    if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h want 00", bus.rd_data); end
  endtask

  // Run 0: idle image, one strobe at 16..19 only. Run 1: write accepted at 20 -> strobe 32..35.
  task automatic test_frame_pacing();
    logic exp;
    for (int run = 0; run < 2; run++) begin
      do_reset();
      for (int k = 1; k <= 40; k++) begin
        @(posedge clk); #1;
        exp = (k >= 16 && k <= 19) || (run == 1 && k >= 32 && k <= 35);
        checks++;
        if (start_o !== exp) begin
          errors++;
          $display("FAIL pacing run%0d cycle %0d start_o got %b want %b", run, k, start_o, exp);
        end
        if (run == 1 && k == 19) begin
          bus.pix_x = 7'd0; bus.pix_y = 6'd0; bus.pix_op = 2'b01; bus.pix_valid = 1'b1;
        end
        if (run == 1 && k == 20) begin
          bus.pix_valid = 1'b0;
          checks++;
          if (bus.pix_ready !== 1'b0) begin errors++; $display("FAIL pacing_accept ready got %b want 0", bus.pix_ready); end
        end
      end
    end
  endtask

  task automatic test_clear();
    int n;
    int bad;
    logic rdy_seen;
    logic [7:0] d;
    bus.pix_op = 2'b11;
    bus.pix_valid = 1'b1;
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
    n = 0;
    rdy_seen = 1'b0;
    while (busy_o && n < 1100) begin
      if (bus.pix_ready) rdy_seen = 1'b1;
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if (n != 1024) begin errors++; $display("FAIL clear_busy_cycles got %0d want 1024", n); end
    checks++;
    if (rdy_seen !== 1'b0) begin errors++; $display("FAIL clear_ready_low got ready-seen=%b want 0", rdy_seen); end
    bad = 0;
    for (int a = 0; a < 1024; a++) begin
      read_byte(10'(a), d);
      if (d !== 8'h00) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL clear_scan nonzero bytes got %0d want 0", bad); end
  endtask

  // (x=5,y=10) maps to {0, page 1, col 5} = 0x045, bit 2; y=13 is bit 5.
  task automatic test_pixel_ops();
    logic [7:0] d;
    pixel_op(7'd5, 6'd10, 2'b01);
    read_byte(10'h045, d);
    checks++;
    if (d !== 8'h04) begin errors++; $display("FAIL set_y10 got %h want 04", d); end
    pixel_op(7'd5, 6'd13, 2'b01);
    read_byte(10'h045, d);
    checks++;
    if (d !== 8'h24) begin errors++; $display("FAIL set_y13 got %h want 24", d); end
    pixel_op(7'd5, 6'd10, 2'b10);
    read_byte(10'h045, d);
    checks++;
    if (d !== 8'h20) begin errors++; $display("FAIL toggle_y10 got %h want 20", d); end
    pixel_op(7'd5, 6'd13, 2'b00);
    read_byte(10'h045, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL clear_y13 got %h want 00", d); end
  endtask

  task automatic test_corner();
    logic [7:0] d;
    pixel_op(7'd127, 6'd63, 2'b01);
    read_byte(10'h3FF, d);
    checks++;
    if (d !== 8'h80) begin errors++; $display("FAIL corner_3ff got %h want 80", d); end
    read_byte(10'h1FF, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL corner_1ff got %h want 00", d); end
    read_byte(10'h3BF, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL corner_3bf got %h want 00", d); end
  endtask

  // Valid held high; inputs only change right after each handshake.
  task automatic test_back_to_back();
    logic [6:0] xs [4];
    logic [5:0] ys [4];
    logic       hs;
    logic [7:0] d;
    int i, n, last;
    xs[0] = 7'd10; ys[0] = 6'd0;
    xs[1] = 7'd10; ys[1] = 6'd1;
    xs[2] = 7'd10; ys[2] = 6'd2;
    xs[3] = 7'd70; ys[3] = 6'd20;
    i = 0; n = 0; last = 0;
    bus.pix_x = xs[0]; bus.pix_y = ys[0]; bus.pix_op = 2'b01; bus.pix_valid = 1'b1;
    while (i < 4 && n < 100) begin
      hs = bus.pix_ready;
      @(posedge clk); #1;
      n++;
      if (hs) begin
        if (i > 0) begin
          checks++;
          if (n - last != 4) begin errors++; $display("FAIL b2b_gap%0d got %0d want 4", i, n - last); end
        end
        last = n;
        i++;
        if (i < 4) begin
          bus.pix_x = xs[i]; bus.pix_y = ys[i];
        end else begin
          bus.pix_valid = 1'b0;
        end
      end
    end
    bus.pix_valid = 1'b0;
    checks++;
    if (i != 4) begin errors++; $display("FAIL b2b_handshakes got %0d want 4", i); end
    n = 0;
    while (!bus.pix_ready && n < 20) begin @(posedge clk); #1; n++; end
    read_byte(10'h00A, d);
    checks++;
    if (d !== 8'h07) begin errors++; $display("FAIL b2b_00a got %h want 07", d); end
    read_byte(10'h286, d);
    checks++;
    if (d !== 8'h10) begin errors++; $display("FAIL b2b_286 got %h want 10", d); end
  endtask

  task automatic test_reset_mid_clear();
    logic [7:0] d;
    logic exp;
    int bad;
    pixel_op(7'd5, 6'd10, 2'b01);
    bus.pix_op = 2'b11;
    bus.pix_valid = 1'b1;
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || bus.pix_ready !== 1'b1 || start_o !== 1'b0) begin
      errors++;
      $display("FAIL midclr_async busy=%b ready=%b start=%b want 0 1 0", busy_o, bus.pix_ready, start_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      exp = (k >= 16 && k <= 19);
      checks++;
      if (start_o !== exp) begin
        errors++;
        $display("FAIL midclr_strobe cycle %0d got %b want %b", k, start_o, exp);
      end
    end
    bad = 0;
    for (int a = 0; a < 500; a++) begin
      read_byte(10'(a), d);
      if (d !== 8'h00) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midclr_scan nonzero bytes got %0d want 0", bad); end
    read_byte(10'h3FF, d);
    checks++;
    if (d !== 8'h80) begin errors++; $display("FAIL midclr_untouched_3ff got %h want 80", d); end
    pixel_op(7'd1, 6'd0, 2'b01);
    read_byte(10'h001, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL midclr_set got %h want 01", d); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_x = 7'd0;
    bus.pix_y = 6'd0;
    bus.pix_op = 2'b00;
    bus.rd_addr = 10'd0;
    test_reset();
    test_frame_pacing();
    test_clear();
    test_pixel_ops();
    test_corner();
    test_back_to_back();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
